// File: rtl/ring_osc_freq_meter_pkg.sv
// Shared constants for the ring-oscillator frequency meter.
// State encoding and default widths used by the top and its bench.
package tof_pkg;

  localparam int CNT_W_DEF  = 24;
  localparam int GATE_W_DEF = 20;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GATE = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchronizer plus edge flop for an asynchronous input.
// rise_p is a one-cycle pulse per rising edge seen in the clk domain.
module sync_rise_detect (
  input  logic clk,
  input  logic resetn,
  input  logic d_async,
  output logic rise_p
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_async;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_p = s2_q & ~s3_q;

endmodule

// File: rtl/ring_osc_freq_meter.sv
// Counts ring-oscillator rising edges over a gate window of clk cycles
// and returns a saturating count through a valid/ready handshake.
module ring_osc_freq_meter
  import tof_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int GATE_W = GATE_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              osc_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  output logic              busy,
  output logic              meas_valid,
  input  logic              meas_ready,
  output logic [CNT_W-1:0]  meas_count,
  output logic              meas_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              edge_p;
  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [GATE_W-1:0] gate_ctr_q;
  logic [GATE_W-1:0] gate_ctr_d;
  logic [CNT_W-1:0]  edge_cnt_q;
  logic [CNT_W-1:0]  edge_cnt_d;
  logic              ovf_q;
  logic              ovf_d;

  // Synchronizer runs in every state so no false edge appears at window start.
  sync_rise_detect u_sync (
    .clk     (clk),
    .resetn  (resetn),
    .d_async (osc_in),
    .rise_p  (edge_p)
  );

  always_comb begin
    state_d    = state_q;
    gate_ctr_d = gate_ctr_q;
    edge_cnt_d = edge_cnt_q;
    ovf_d      = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_GATE;
          gate_ctr_d = (gate_len == '0) ? '0
                                        : gate_len - GATE_W'(1);
          edge_cnt_d = '0;
          ovf_d      = 1'b0;
        end
      end
      ST_GATE: begin
        if (edge_p) begin
          if (edge_cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            edge_cnt_d = edge_cnt_q + CNT_W'(1);
          end
        end
        if (gate_ctr_q == '0) begin
          state_d = ST_HOLD;
        end else begin
          gate_ctr_d = gate_ctr_q - GATE_W'(1);
        end
      end
      ST_HOLD: begin
        if (meas_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      gate_ctr_q <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_ctr_q <= gate_ctr_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy       = (state_q == ST_GATE) || (state_q == ST_HOLD);
  assign meas_valid = (state_q == ST_HOLD);
  assign meas_count = edge_cnt_q;
  assign meas_ovf   = ovf_q;

endmodule
